crc_frame_arbiter: RTL and testbench

Frame-level controller that shares one `slicing_crc` engine between `NUM_REQ` streaming requesters. It grants the engine to one requester for a whole frame using round-robin arbitration, and feeds that frame's beats into the engine as a contiguous byte mask. It then captures the finished CRC, byte length and requester ID into a result register with a valid/ready handshake, and clears the engine before the next frame. It sits between the packet sources (MAC TX/RX framers) and the single CRC engine instance, which is built with `REGISTER_OUTPUT=1`.

---
 rtl/crc_frame_arbiter.sv | 167 ++++++++++++++++
 tb/tb_crc_frame_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_arbiter.sv
// Shares one slicing_crc engine between NUM_REQ requesters, one whole frame at a time,
// with round-robin grant and a valid/ready result register (CRC, byte length, owner).
module crc_frame_arbiter #(
    parameter int  SLICE_LENGTH = 8,
    parameter int  NUM_REQ      = 2,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ*8*SLICE_LENGTH-1:0] s_data,
    input  logic [NUM_REQ*SLICE_LENGTH-1:0]   s_keep,
    input  logic [NUM_REQ-1:0]                s_last,
    input  logic [NUM_REQ-1:0]                s_valid,
    output logic [NUM_REQ-1:0]                s_ready,
    output logic [8*SLICE_LENGTH-1:0]         eng_data,
    output logic [SLICE_LENGTH-1:0]           eng_valid,
    output logic                              eng_reset,
    input  logic [31:0]                       eng_crc,
    output logic [31:0]                       res_crc,
    output logic [15:0]                       res_len,
    output logic [ID_W-1:0]                   res_id,
    output logic                              res_valid,
    input  logic                              res_ready
);
    localparam int BEAT_W = 8*SLICE_LENGTH;
    localparam int CNT_W  = $clog2(SLICE_LENGTH+1);

    typedef enum logic [1:0] {IDLE, STREAM, CAPTURE, RESULT} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [15:0]     len_q, len_d;
    logic [31:0]     res_crc_q, res_crc_d;
    logic [15:0]     res_len_q, res_len_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic            res_valid_q, res_valid_d;

    logic [BEAT_W-1:0]       data_a [NUM_REQ];
    logic [SLICE_LENGTH-1:0] keep_a [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign data_a[r] = s_data[r*BEAT_W +: BEAT_W];
        assign keep_a[r] = s_keep[r*SLICE_LENGTH +: SLICE_LENGTH];
    end

    logic [BEAT_W-1:0]       g_data;
    logic [SLICE_LENGTH-1:0] g_keep;
    logic                    g_valid, g_last;

    assign g_data  = data_a[grant_q];
    assign g_keep  = keep_a[grant_q];
    assign g_valid = s_valid[grant_q];
    assign g_last  = s_last[grant_q];

    logic [CNT_W-1:0] keep_cnt;
    logic [16:0]      len_sum;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < SLICE_LENGTH; i++) keep_cnt = keep_cnt + CNT_W'(g_keep[i]);
    end

    assign len_sum = {1'b0, len_q} + 17'(keep_cnt);

    // Round-robin: first valid requester strictly after last_grant, wrapping.
    logic            rr_found;
    logic [ID_W-1:0] rr_pick, rr_cand;
    int unsigned     rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant_q;
        rr_cand  = '0;
        rr_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx  = (int'(last_grant_q) + k) % NUM_REQ;
            rr_cand = ID_W'(rr_idx);
            if (!rr_found && s_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        res_crc_d    = res_crc_q;
        res_len_d    = res_len_q;
        res_id_d     = res_id_q;
        res_valid_d  = res_valid_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    len_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (g_valid) begin
                    len_d = len_sum[16] ? 16'hFFFF : len_sum[15:0];
                    if (g_last) begin
                        last_grant_d = grant_q;
                        state_d      = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                // Engine output is registered, so the last beat's CRC is visible here.
                res_crc_d   = eng_crc;
                res_len_d   = len_q;
                res_id_d    = grant_q;
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ-1);
            len_q        <= '0;
            res_crc_q    <= '0;
            res_len_q    <= '0;
            res_id_q     <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            res_crc_q    <= res_crc_d;
            res_len_q    <= res_len_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
        end
    end

    always_comb begin
        s_ready = '0;
        if (state_q == STREAM && !reset) s_ready[grant_q] = 1'b1;
    end

    assign eng_data  = g_data;
    assign eng_valid = (state_q == STREAM && g_valid && !reset) ? g_keep : '0;
    // Clearing at the handshake edge is safe: the CRC was sampled in CAPTURE.
    assign eng_reset = reset | (state_q == RESULT && res_ready);

    assign res_crc   = res_crc_q;
    assign res_len   = res_len_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Randomized bench for crc_frame_arbiter: behavioural CRC engine, frame-level
// reference (byte-list CRC, saturating length, abstract round-robin order).
module tb_crc_frame_arbiter;
    localparam int NUM_REQ = 2;
    localparam int SL      = 8;
    localparam int BW      = 8*SL;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int LIMIT   = 20000;

    typedef struct packed {
        logic          vld;
        logic          last;
        logic [SL-1:0] keep;
        logic [BW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [31:0] crc;
        logic [15:0] len;
        logic [7:0]  id;
    } res_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ*BW-1:0]   s_data;
    logic [NUM_REQ*SL-1:0]   s_keep;
    logic [NUM_REQ-1:0]      s_last, s_valid, s_ready;
    logic [BW-1:0]           eng_data;
    logic [SL-1:0]           eng_valid;
    logic                    eng_reset;
    logic [31:0]             eng_crc;
    logic [31:0]             res_crc;
    logic [15:0]             res_len;
    logic [ID_W-1:0]         res_id;
    logic                    res_valid, res_ready;

    int tests = 0;
    int fails = 0;

    beat_t      bq     [NUM_REQ][$];
    res_t       exp_fr [NUM_REQ][$];
    res_t       exp_q  [$];
    res_t       got_q  [$];
    logic [7:0] fb     [$];
    int         model_lg = NUM_REQ-1;

    crc_frame_arbiter #(.SLICE_LENGTH(SL), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .eng_data(eng_data), .eng_valid(eng_valid), .eng_reset(eng_reset), .eng_crc(eng_crc),
        .res_crc(res_crc), .res_len(res_len), .res_id(res_id),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    function automatic logic [31:0] eng_upd(input logic [31:0] c, input logic [BW-1:0] d,
                                            input logic [SL-1:0] v);
        logic [31:0] x = c;
        int n = 0;
        for (int i = 0; i < SL; i++) if (v[i]) n = i + 1;
        for (int i = 0; i < n; i++) x = crc_byte(x, d[8*i +: 8]);
        return x;
    endfunction

    // Engine stand-in: state cleared by eng_reset, output already inverted and registered.
    logic [31:0] eng_st;
    always @(posedge clk) begin
        if (eng_reset) eng_st <= 32'hFFFFFFFF;
        else if (eng_valid != '0) eng_st <= eng_upd(eng_st, eng_data, eng_valid);
    end
    assign eng_crc = ~eng_st;

    function automatic logic [31:0] crc_fb();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (fb[i]) c = crc_byte(c, fb[i]);
        return ~c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_str(input string s);
        fb.delete();
        for (int i = 0; i < s.len(); i++) fb.push_back(s[i]);
    endtask

    task automatic fill_rand(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    endtask

    // Turn the byte list in fb into beats (with optional mid-frame idle beats) for requester r.
    task automatic add_frame(input int r, input int gap_pct);
        int    nb  = fb.size();
        int    pos = 0;
        beat_t b;
        res_t  e;
        e.crc = crc_fb();
        e.len = (nb > 65535) ? 16'hFFFF : 16'(nb);
        e.id  = 8'(r);
        exp_fr[r].push_back(e);
        if (nb == 0) begin
            b = '0; b.vld = 1'b1; b.last = 1'b1; b.data = {$urandom, $urandom};
            bq[r].push_back(b);
        end
        while (pos < nb) begin
            int n = (nb - pos > SL) ? SL : nb - pos;
            int g = 0;
            while (pos > 0 && g < 3 && $urandom_range(99) < gap_pct) begin
                b = '0; b.vld = 1'($urandom_range(1)); b.data = {$urandom, $urandom};
                bq[r].push_back(b);
                g++;
            end
            b.vld  = 1'b1;
            b.last = (pos + n == nb);
            b.keep = SL'((1 << n) - 1);
            b.data = {$urandom, $urandom};
            for (int i = 0; i < n; i++) b.data[8*i +: 8] = fb[pos+i];
            bq[r].push_back(b);
            pos += n;
        end
    endtask

    function automatic bit pending();
        for (int r = 0; r < NUM_REQ; r++) if (bq[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // mode 0: res_ready always high; 1: random; 2: hold low for 'hold' result cycles.
    task automatic run(input int mode, input int hold);
        int          cyc = 0, hs = -1, last_acc = -100, rv_cnt = 0, g;
        logic        prev_rv = 1'b0, any_ready = 1'b0;
        logic [47:0] held = '0;
        logic [63:0] exp_ev;
        bit          found = 1'b1;
        exp_q.delete();
        got_q.delete();
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ && !found; k++) begin
                int r = (model_lg + k) % NUM_REQ;
                if (exp_fr[r].size() > 0) begin
                    exp_q.push_back(exp_fr[r].pop_front());
                    model_lg = r;
                    found    = 1'b1;
                end
            end
        end
        while ((pending() || exp_q.size() > 0) && cyc < LIMIT) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (bq[r].size() > 0) begin
                    s_valid[r]             = bq[r][0].vld;
                    s_last[r]              = bq[r][0].last;
                    s_keep[r*SL +: SL]     = bq[r][0].keep;
                    s_data[r*BW +: BW]     = bq[r][0].data;
                end else begin
                    s_valid[r]             = 1'b0;
                    s_last[r]              = 1'b0;
                    s_keep[r*SL +: SL]     = '0;
                    s_data[r*BW +: BW]     = {$urandom, $urandom};
                end
            end
            case (mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(1));
                default: res_ready = res_valid && (rv_cnt >= hold);
            endcase
            #1;
            g = -1;
            for (int r = 0; r < NUM_REQ; r++) if (s_ready[r]) g = r;
            if (s_ready != '0) begin
                if (exp_q.size() == 0) chk("spurious_grant", s_ready, 0);
                else chk("grant", s_ready, 64'(1) << exp_q[0].id);
                if (!any_ready) chk("grant_latency", cyc, hs + 2);
                chk("eng_data", eng_data, s_data[g*BW +: BW]);
            end
            exp_ev = (g >= 0 && s_valid[g]) ? 64'(s_keep[g*SL +: SL]) : 64'h0;
            chk("eng_valid", eng_valid, exp_ev);
            chk("eng_reset", eng_reset, res_valid & res_ready);
            if (res_valid) begin
                chk("ready_in_result", s_ready, 0);
                if (!prev_rv) begin
                    chk("result_latency", cyc, last_acc + 2);
                    held = {res_crc, res_len};
                end else begin
                    chk("result_stable", {res_crc, res_len}, held);
                end
                rv_cnt++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stale_result", res_valid, 0);
                end else begin
                    chk("res_crc", res_crc, exp_q[0].crc);
                    chk("res_len", res_len, exp_q[0].len);
                    chk("res_id",  res_id,  exp_q[0].id);
                    got_q.push_back('{res_crc, res_len, 8'(res_id)});
                    void'(exp_q.pop_front());
                end
                hs     = cyc;
                rv_cnt = 0;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (s_ready[r] && bq[r].size() > 0) begin
                    if (bq[r][0].vld && bq[r][0].last) last_acc = cyc;
                    void'(bq[r].pop_front());
                end
            end
            prev_rv   = res_valid;
            any_ready = (s_ready != '0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("frames_left", exp_q.size(), 0);
        s_valid = '0; s_keep = '0; s_last = '0; res_ready = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_result", res_valid, 0);
    endtask

    task automatic chk_got(input int i, input logic [31:0] c, input logic [15:0] l, input logic [7:0] id);
        if (got_q.size() <= i) begin
            chk("got_missing", got_q.size(), i + 1);
        end else begin
            chk("dir_crc", got_q[i].crc, c);
            chk("dir_len", got_q[i].len, l);
            chk("dir_id",  got_q[i].id,  id);
        end
    endtask

    initial begin
        reset = 1'b1; s_data = '0; s_keep = '1; s_last = '0; s_valid = '1; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_crc",   res_crc,   0);
        chk("rst_res_len",   res_len,   0);
        chk("rst_res_id",    res_id,    0);
        chk("rst_s_ready",   s_ready,   0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_eng_reset", eng_reset, 1);
        reset = 1'b0; s_valid = '0; s_keep = '0;
        @(posedge clk); #1;
        chk("post_rst_ready", s_ready, 0);

        // Single 9-byte frame from requester 0.
        fill_str("123456789"); add_frame(0, 0);
        run(0, 0);
        chk_got(0, 32'hCBF43926, 16'd9, 8'd0);

        // Empty frame.
        fill_str(""); add_frame(0, 0);
        run(0, 0);
        chk_got(0, 32'h0, 16'd0, 8'd0);

        // Both requesters loaded: grants alternate, requester 1 first.
        fill_str("123456789"); add_frame(1, 0);
        for (int i = 0; i < 3; i++) begin fill_rand($urandom_range(1, 8)); add_frame(1, 0); end
        for (int i = 0; i < 4; i++) begin fill_rand($urandom_range(1, 8)); add_frame(0, 0); end
        run(0, 0);
        chk_got(0, 32'hCBF43926, 16'd9, 8'd1);
        if (got_q.size() >= 4) begin
            chk("rr_id1", got_q[1].id, 0);
            chk("rr_id2", got_q[2].id, 1);
            chk("rr_id3", got_q[3].id, 0);
        end else chk("rr_count", got_q.size(), 4);

        // Result backpressure for 10 cycles, with a second frame waiting.
        fill_rand(13); add_frame(0, 0);
        fill_str("123456789"); add_frame(1, 0);
        run(2, 10);

        // Reset after the first beat of a frame, then resend it whole.
        s_data = '0; s_data[0 +: BW] = 64'h3837363534333231; s_keep = '0; s_keep[0 +: SL] = '1;
        s_valid = 2'b01;
        @(posedge clk); #1;
        chk("mf_ready", s_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1; s_valid = '0; s_keep = '0;
        #1;
        chk("mf_eng_reset", eng_reset, 1);
        chk("mf_ready_rst", s_ready, 0);
        @(posedge clk); #1; @(posedge clk); #1;
        chk("mf_res_valid", res_valid, 0);
        reset = 1'b0;
        model_lg = NUM_REQ - 1;
        @(posedge clk); #1;
        fill_str("123456789"); add_frame(0, 0);
        run(0, 0);
        chk_got(0, 32'hCBF43926, 16'd9, 8'd0);

        // Idle and empty beats inside a frame.
        fill_rand(20); add_frame(1, 70);
        run(0, 0);

        // Random traffic on both requesters with random result backpressure.
        for (int i = 0; i < 30; i++) begin
            fill_rand($urandom_range(0, 40));
            add_frame(int'($urandom_range(NUM_REQ - 1)), 30);
        end
        run(1, 0);

        // Length saturation.
        fill_rand(65600); add_frame(1, 0);
        run(0, 0);
        if (got_q.size() > 0) chk("sat_len", got_q[0].len, 16'hFFFF);
        else chk("sat_missing", got_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
